pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/ctrl_decode.sv | 56 +++++
 rtl/pipe_ctrl.sv | 129 ++++++++++++
 tb/tb_pipe_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared opcodes, ID/EX control bundle and FSM state encoding for the pipeline controller.
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_LW  = 4'b1000;
  localparam logic [3:0] OP_SW  = 4'b1001;
  localparam logic [3:0] OP_LLB = 4'b1010;
  localparam logic [3:0] OP_LHB = 4'b1011;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_PCS = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef struct packed {
    logic       regdst;
    logic [1:0] branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control bundle plus which register specifiers are read.
module ctrl_decode
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0]   i_opcode,
  output ctrl_bundle_t o_ctrl,
  output logic         o_uses_rs,
  output logic         o_uses_rt,
  output logic         o_uses_rd
);

  always_comb begin
    o_ctrl    = '0;
    o_uses_rs = 1'b0;
    o_uses_rt = 1'b0;
    o_uses_rd = 1'b0;
    if (!i_opcode[3]) begin
      o_ctrl.regdst   = 1'b1;
      o_ctrl.regwrite = 1'b1;
      o_uses_rs       = 1'b1;
      o_uses_rt       = 1'b1;
    end else begin
      case (i_opcode)
        OP_LW: begin
          o_ctrl.memread  = 1'b1;
          o_ctrl.memtoreg = 1'b1;
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_uses_rs       = 1'b1;
        end
        OP_SW: begin
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.memwrite = 1'b1;
          o_uses_rs       = 1'b1;
          o_uses_rt       = 1'b1;
        end
        OP_LLB, OP_LHB: begin
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.regwrite = 1'b1;
          o_uses_rd       = 1'b1;
        end
        OP_B:  o_ctrl.branch = 2'b11;
        OP_BR: begin
          o_ctrl.branch = 2'b10;
          o_uses_rs     = 1'b1;
        end
        OP_PCS: begin
          o_ctrl.alusrc   = 1'b1;
          o_ctrl.regwrite = 1'b1;
        end
        default: o_ctrl = '0;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: load-use stall, branch flush, ID/EX control register and HLT drain FSM.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned RA_W         = 4,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned SCNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              ex_memread,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              br_taken,
  output logic              pc_hold,
  output logic              ifid_flush,
  output logic              idex_valid,
  output logic              idex_regdst,
  output logic [1:0]        idex_branch,
  output logic              idex_memread,
  output logic              idex_memtoreg,
  output logic              idex_memwrite,
  output logic              idex_alusrc,
  output logic              idex_regwrite,
  output logic              halted,
  output logic [SCNT_W-1:0] stall_cnt
);

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_drain_cnt, w_drain_cnt_nxt;
  ctrl_bundle_t r_idex, w_idex_nxt;
  logic         r_idex_valid, w_idex_valid_nxt;
  logic         r_halted, w_halted_nxt;
  logic [SCNT_W-1:0] r_stall_cnt;

  ctrl_bundle_t w_dec;
  logic         w_uses_rs, w_uses_rt, w_uses_rd;
  logic         w_hazard, w_stall;

  ctrl_decode u_decode (
    .i_opcode  (id_opcode),
    .o_ctrl    (w_dec),
    .o_uses_rs (w_uses_rs),
    .o_uses_rt (w_uses_rt),
    .o_uses_rd (w_uses_rd)
  );

  assign w_hazard = id_valid && ex_memread && (ex_rd != '0) &&
                    ((w_uses_rs && (id_rs == ex_rd)) ||
                     (w_uses_rt && (id_rt == ex_rd)) ||
                     (w_uses_rd && (id_rd == ex_rd)));
  assign w_stall  = (r_state == RUN) && w_hazard;

  always_comb begin
    w_state_nxt      = r_state;
    w_drain_cnt_nxt  = r_drain_cnt;
    w_idex_nxt       = '0;
    w_idex_valid_nxt = 1'b0;
    w_halted_nxt     = r_halted;
    pc_hold          = 1'b0;
    ifid_flush       = 1'b0;
    case (r_state)
      RUN: begin
        if (w_hazard) begin
          pc_hold = 1'b1;
        end else begin
          ifid_flush       = br_taken;
          w_idex_valid_nxt = id_valid;
          if (id_valid) w_idex_nxt = w_dec;
          // HLT itself enters EX as a valid all-zero bundle; fetch freezes immediately.
          if (id_valid && (id_opcode == OP_HLT)) begin
            pc_hold         = 1'b1;
            w_state_nxt     = DRAIN;
            w_drain_cnt_nxt = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        pc_hold         = 1'b1;
        w_drain_cnt_nxt = r_drain_cnt - 4'd1;
        if (r_drain_cnt <= 4'd1) begin
          w_state_nxt  = HALTED;
          w_halted_nxt = 1'b1;
        end
      end
      HALTED: begin
        pc_hold      = 1'b1;
        w_halted_nxt = 1'b1;
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= RUN;
      r_drain_cnt  <= '0;
      r_idex       <= '0;
      r_idex_valid <= 1'b0;
      r_halted     <= 1'b0;
      r_stall_cnt  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_drain_cnt  <= w_drain_cnt_nxt;
      r_idex       <= w_idex_nxt;
      r_idex_valid <= w_idex_valid_nxt;
      r_halted     <= w_halted_nxt;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  assign idex_valid    = r_idex_valid;
  assign idex_regdst   = r_idex.regdst;
  assign idex_branch   = r_idex.branch;
  assign idex_memread  = r_idex.memread;
  assign idex_memtoreg = r_idex.memtoreg;
  assign idex_memwrite = r_idex.memwrite;
  assign idex_alusrc   = r_idex.alusrc;
  assign idex_regwrite = r_idex.regwrite;
  assign halted        = r_halted;
  assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default instance plus a 2-bit stall-counter instance on shared inputs.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_opcode, id_rs, id_rt, id_rd;
  logic       ex_memread;
  logic [3:0] ex_rd;
  logic       br_taken;

  logic        a_hold, a_flush, a_valid, a_regdst, a_memread, a_memtoreg, a_memwrite, a_alusrc, a_regwrite, a_halted;
  logic [1:0]  a_branch;
  logic [15:0] a_scnt;
  logic        b_hold, b_flush, b_valid, b_regdst, b_memread, b_memtoreg, b_memwrite, b_alusrc, b_regwrite, b_halted;
  logic [1:0]  b_branch;
  logic [1:0]  b_scnt;

  always #5 clk = ~clk;

  pipe_ctrl dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .br_taken(br_taken), .pc_hold(a_hold), .ifid_flush(a_flush), .idex_valid(a_valid),
    .idex_regdst(a_regdst), .idex_branch(a_branch), .idex_memread(a_memread),
    .idex_memtoreg(a_memtoreg), .idex_memwrite(a_memwrite), .idex_alusrc(a_alusrc),
    .idex_regwrite(a_regwrite), .halted(a_halted), .stall_cnt(a_scnt)
  );

  pipe_ctrl #(.SCNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_memread(ex_memread), .ex_rd(ex_rd),
    .br_taken(br_taken), .pc_hold(b_hold), .ifid_flush(b_flush), .idex_valid(b_valid),
    .idex_regdst(b_regdst), .idex_branch(b_branch), .idex_memread(b_memread),
    .idex_memtoreg(b_memtoreg), .idex_memwrite(b_memwrite), .idex_alusrc(b_alusrc),
    .idex_regwrite(b_regwrite), .halted(b_halted), .stall_cnt(b_scnt)
  );

  // Bundle packing: {valid, regdst, branch[1:0], memread, memtoreg, memwrite, alusrc, regwrite}
  localparam logic [8:0] B_NONE = 9'h000;
  localparam logic [8:0] B_ALU  = 9'h181;
  localparam logic [8:0] B_IMM  = 9'h103;
  localparam logic [8:0] B_BR   = 9'h160;
  localparam logic [8:0] B_LW   = 9'h11B;
  localparam logic [8:0] B_HLT  = 9'h100;

  typedef struct {
    string       tag;
    logic [8:0]  bnd;
    logic        hlt;
    logic [15:0] sc;
    logic [1:0]  sc2;
  } exp_t;

  exp_t sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  function automatic logic [8:0] bnd_a();
    return {a_valid, a_regdst, a_branch, a_memread, a_memtoreg, a_memwrite, a_alusrc, a_regwrite};
  endfunction

  function automatic logic [8:0] bnd_b();
    return {b_valid, b_regdst, b_branch, b_memread, b_memtoreg, b_memwrite, b_alusrc, b_regwrite};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [8:0] bnd, input logic hlt,
                            input logic [15:0] sc, input logic [1:0] sc2);
    chk({tag, ".bndA"}, 32'(bnd_a()), 32'(bnd));
    chk({tag, ".bndB"}, 32'(bnd_b()), 32'(bnd));
    chk({tag, ".hltA"}, 32'(a_halted), 32'(hlt));
    chk({tag, ".hltB"}, 32'(b_halted), 32'(hlt));
    chk({tag, ".scA"},  32'(a_scnt), 32'(sc));
    chk({tag, ".scB"},  32'(b_scnt), 32'(sc2));
  endtask

  task automatic check_comb(input string tag, input logic hold, input logic flush);
    chk({tag, ".holdA"},  32'(a_hold),  32'(hold));
    chk({tag, ".holdB"},  32'(b_hold),  32'(hold));
    chk({tag, ".flushA"}, 32'(a_flush), 32'(flush));
    chk({tag, ".flushB"}, 32'(b_flush), 32'(flush));
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] op,
                      input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                      input logic exm, input logic [3:0] exrd, input logic br,
                      input logic hold, input logic flush,
                      input logic [8:0] bnd, input logic hlt,
                      input logic [15:0] sc, input logic [1:0] sc2);
    exp_t e;
    id_valid = v; id_opcode = op; id_rs = rs; id_rt = rt; id_rd = rd;
    ex_memread = exm; ex_rd = exrd; br_taken = br;
    #1;
    check_comb(tag, hold, flush);
    e.tag = tag; e.bnd = bnd; e.hlt = hlt; e.sc = sc; e.sc2 = sc2;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed none expected one entry", tag);
    end else begin
      e = sb.pop_front();
      check_regs(e.tag, e.bnd, e.hlt, e.sc, e.sc2);
    end
  endtask

  task automatic idle_inputs();
    id_valid = 1'b0; id_opcode = 4'h0; id_rs = 4'h0; id_rt = 4'h0; id_rd = 4'h0;
    ex_memread = 1'b0; ex_rd = 4'h0; br_taken = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    #1;
    check_regs(tag, B_NONE, 1'b0, 16'd0, 2'd0);
    check_comb(tag, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_regs("reset", B_NONE, 1'b0, 16'd0, 2'd0);
    check_comb("reset", 1'b0, 1'b0);
    rst = 1'b0;

    //   tag            v   op     rs     rt     rd   exm exrd   br  hold flush bundle  hlt  scA  scB
    step("add",        1, 4'h0, 4'h1, 4'h2, 4'h3, 0, 4'h0, 0,  0, 0,  B_ALU,  0, 16'd0, 2'd0);
    step("sub_haz",    1, 4'h1, 4'h1, 4'h5, 4'h3, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd1, 2'd1);
    step("sub_rd0",    1, 4'h1, 4'h1, 4'h0, 4'h3, 1, 4'h0, 0,  0, 0,  B_ALU,  0, 16'd1, 2'd1);
    step("llb_haz",    1, 4'hA, 4'h7, 4'h7, 4'h3, 1, 4'h3, 0,  1, 0,  B_NONE, 0, 16'd2, 2'd2);
    step("llb",        1, 4'hA, 4'h7, 4'h7, 4'h3, 0, 4'h3, 0,  0, 0,  B_IMM,  0, 16'd2, 2'd2);
    step("b_taken",    1, 4'hC, 4'h0, 4'h0, 4'h0, 0, 4'h0, 1,  0, 1,  B_BR,   0, 16'd2, 2'd2);
    step("br_haz",     1, 4'hD, 4'h4, 4'h0, 4'h0, 1, 4'h4, 1,  1, 0,  B_NONE, 0, 16'd3, 2'd3);
    step("lw_rt_free", 1, 4'h8, 4'h2, 4'h4, 4'h0, 1, 4'h4, 0,  0, 0,  B_LW,   0, 16'd3, 2'd3);
    step("sw_haz",     1, 4'h9, 4'h1, 4'h6, 4'h0, 1, 4'h6, 0,  1, 0,  B_NONE, 0, 16'd4, 2'd3);
    step("pcs",        1, 4'hE, 4'h6, 4'h6, 4'h6, 1, 4'h6, 0,  0, 0,  B_IMM,  0, 16'd4, 2'd3);

    do_reset("rst1");
    step("sat1",       1, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd1, 2'd1);
    step("sat2",       1, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd2, 2'd2);
    step("sat3",       1, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd3, 2'd3);
    step("sat4",       1, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd4, 2'd3);
    step("sat5",       1, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 0, 16'd5, 2'd3);
    step("id_invalid", 0, 4'h0, 4'h5, 4'h1, 4'h0, 1, 4'h5, 0,  0, 0,  B_NONE, 0, 16'd5, 2'd3);

    do_reset("rst2");
    step("hlt",        1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0,  1, 0,  B_HLT,  0, 16'd0, 2'd0);
    step("drain1",     1, 4'h0, 4'h5, 4'h5, 4'h0, 1, 4'h5, 1,  1, 0,  B_NONE, 0, 16'd0, 2'd0);
    step("drain2",     1, 4'h0, 4'h5, 4'h5, 4'h0, 1, 4'h5, 1,  1, 0,  B_NONE, 0, 16'd0, 2'd0);
    step("drain3",     1, 4'h0, 4'h5, 4'h5, 4'h0, 1, 4'h5, 1,  1, 0,  B_NONE, 1, 16'd0, 2'd0);
    step("halted1",    1, 4'h0, 4'h1, 4'h2, 4'h0, 0, 4'h0, 1,  1, 0,  B_NONE, 1, 16'd0, 2'd0);
    step("halted2",    1, 4'h0, 4'h5, 4'h5, 4'h0, 1, 4'h5, 0,  1, 0,  B_NONE, 1, 16'd0, 2'd0);

    do_reset("rst3");
    step("hlt_b",      1, 4'hF, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0,  1, 0,  B_HLT,  0, 16'd0, 2'd0);
    step("drain_b1",   0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 0,  1, 0,  B_NONE, 0, 16'd0, 2'd0);
    do_reset("rst_mid_drain");
    step("after_rst",  1, 4'h0, 4'h1, 4'h2, 4'h3, 0, 4'h0, 0,  0, 0,  B_ALU,  0, 16'd0, 2'd0);
    step("after_rst2", 0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 4'h0, 1,  0, 1,  B_NONE, 0, 16'd0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
